mio_bus_ctrl: RTL and testbench
===============================

# mio_bus_ctrl

Parametrised memory/IO bus controller between the CPU core's data-memory port (`CPU_MIO` / `mem_w` / `Addr_out` / `Data_out` / `Data_in`) and up to `NCH` peripheral channels. It closes the `MIO_ready` handshake that the single-cycle core ignores.
- Every access is decoded to one channel, held until that channel answers, and a per-access `stall` is returned so the core can freeze its PC.
- Adds byte enables, a bounded-wait timeout with error reporting, and configurable data width and channel count.

## Interface
Parameters:
- `DW`, 32, data width in bits; multiple of 8.
- `AW`, 32, address width.
- `NCH`, 4, number of peripheral channels; power of 2, ≥2.
- `TIMEOUT`, 15, maximum WAIT cycles before an access is aborted; ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `cpu_req` in 1: access request (core's `CPU_MIO`); held high until `cpu_done`.
- `cpu_we` in 1: 1 = write (core's `mem_w`).
- `cpu_addr` in AW: byte address.
- `cpu_wdata` in DW: write data.
- `cpu_be` in DW/8: byte enables.
- `cpu_rdata` out DW: read data; valid only while `cpu_done`=1.
- `cpu_done` out 1: one-cycle completion pulse.
- `cpu_err` out 1: qualifies `cpu_done`; 1 = timeout.
- `stall` out 1: `cpu_req & ~cpu_done`, combinational.
- `ch_req` out NCH: one-hot channel request.
- `ch_we` out 1, `ch_addr` out AW, `ch_wdata` out DW, `ch_be` out DW/8: registered, shared by all channels.
- `ch_ready` in NCH: per-channel completion.
- `ch_rdata` in NCH*DW: flattened per-channel read data; channel k = bits [k*DW +: DW].

## Operation
- Channel select: `sel = cpu_addr[AW-1 -: log2(NCH)]`.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On `cpu_req`=1, register addr, wdata, be, we and sel; clear the timeout counter; go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - `ch_req[sel_q]`=1 and all other bits 0; `ch_*` outputs stable for the whole state.
  - Counter increments every WAIT cycle.
  - If `ch_ready[sel_q]`=1: capture `ch_rdata` of `sel_q` (writes capture 0); go to DONE with err=0.
  - Else, if counter == TIMEOUT-1: capture rdata = 0; go to DONE with err=1.
  - `ch_ready` of non-selected channels is ignored.
- DONE:
  - `cpu_done`=1, `cpu_rdata` = captured value, `cpu_err` = captured flag.
  - Always returns to IDLE. `cpu_req` is not sampled in DONE; back-to-back accesses are accepted in the following IDLE cycle.
- `cpu_req` dropped during WAIT (protocol violation): the access still completes normally; no abort.
- Reset values: state IDLE, `ch_req`=0, `ch_we`=0, `ch_addr`/`ch_wdata`/`ch_be`=0, `cpu_rdata`=0, `cpu_done`=0, `cpu_err`=0, counter 0.

## Timing
- Accept at edge E0 (IDLE). `ch_req` is high from E0 onward.
- `ch_ready` seen at edge E0+n (n ≥ 1, the nth WAIT cycle) → `cpu_done` high for the cycle after E0+n.
- Minimum access is 3 cycles (IDLE, WAIT, DONE); `stall` is high for 2 of them.
- Timeout: with no ready, `cpu_done`/`cpu_err` assert after exactly TIMEOUT WAIT cycles.
- Ready on the same edge as the timeout: ready wins, err=0.
- Reset asserted mid-access: all outputs go to reset values immediately (asynchronously), including `ch_req`=0. The in-flight access is lost and no `cpu_done` is produced.
- Outputs `ch_*`, `cpu_rdata`, `cpu_done`, `cpu_err` are all registered; only `stall` is combinational.

## Structure
- Shared package `mio_pkg`:
  - state encoding (IDLE=2'b00, WAIT=2'b01, DONE=2'b10);
  - `CLOG2` helper function;
  - default parameter constants.
- One sub-module, `mio_timeout_cnt`: counter with clear, enable and terminal-count output, width `CLOG2(TIMEOUT+1)`.
- The FSM, decode and read mux live in `mio_bus_ctrl`.

## Test plan
- Read, ch2, ready on the first WAIT cycle; `cpu_addr`=32'h8000_0010, `ch_rdata[2]`=32'hDEAD_BEEF → `ch_req`=4'b0100; `cpu_done` 2 cycles after accept; `cpu_rdata`=32'hDEAD_BEEF; err=0; `stall` high for 2 cycles.
- Write, ch0, be=4'b0011, wdata=32'h1234_5678, ready after 5 WAIT cycles → `ch_wdata`/`ch_be` stable for all 5 cycles; `cpu_done` in the 6th cycle after accept; err=0.
- Ch1 never ready, TIMEOUT=15 → `cpu_done` & `cpu_err`=1 after 15 WAIT cycles; `cpu_rdata`=0; `ch_req` drops in DONE.
- Ch1 ready on the 15th WAIT cycle, and ch3 ready during every WAIT cycle → err=0; rdata comes from ch1; ch3 ignored.
- Two back-to-back reads with `cpu_req` held high → the second access is accepted in the IDLE cycle right after DONE; each access takes 3 cycles with 1-cycle ready.
- `rst`=0 asserted in the 3rd WAIT cycle → `ch_req`=0 and all outputs reset immediately (before the next edge); no `cpu_done`; after release, a new access completes normally.

Source files
------------

// File: rtl/mio_pkg.sv
// Shared types and helpers for the memory/IO bus controller.
package mio_pkg;

  localparam int DW_DEF      = 32;
  localparam int AW_DEF      = 32;
  localparam int NCH_DEF     = 4;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } mio_state_e;

  function automatic int CLOG2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/mio_timeout_cnt.sv
// WAIT-cycle counter; tc_o flags the last cycle an access may wait for ready.
module mio_timeout_cnt
  import mio_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = CLOG2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mio_bus_ctrl.sv
// CPU data-port to peripheral-channel bridge: decodes one channel per access,
// holds it until ready or timeout, and returns a done/err pulse plus stall.
module mio_bus_ctrl
  import mio_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter int NCH     = NCH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DW-1:0]     cpu_wdata,
  input  logic [DW/8-1:0]   cpu_be,
  output logic [DW-1:0]     cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic              stall,
  output logic [NCH-1:0]    ch_req,
  output logic              ch_we,
  output logic [AW-1:0]     ch_addr,
  output logic [DW-1:0]     ch_wdata,
  output logic [DW/8-1:0]   ch_be,
  input  logic [NCH-1:0]    ch_ready,
  input  logic [NCH*DW-1:0] ch_rdata
);

  localparam int SW = CLOG2(NCH);
  localparam int BW = DW / 8;

  mio_state_e      state_q, state_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [NCH-1:0]  ch_req_q, ch_req_d;
  logic            ch_we_q, ch_we_d;
  logic [AW-1:0]   ch_addr_q, ch_addr_d;
  logic [DW-1:0]   ch_wdata_q, ch_wdata_d;
  logic [BW-1:0]   ch_be_q, ch_be_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            cnt_clr, cnt_en, cnt_tc;
  logic [DW-1:0]   rd_sel;

  mio_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < NCH; k++)
      if (sel_q == SW'(k)) rd_sel = ch_rdata[k*DW +: DW];
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ch_req_d   = ch_req_q;
    ch_we_d    = ch_we_q;
    ch_addr_d  = ch_addr_q;
    ch_wdata_d = ch_wdata_q;
    ch_be_d    = ch_be_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          sel_d      = cpu_addr[AW-1 -: SW];
          ch_req_d   = NCH'(1) << cpu_addr[AW-1 -: SW];
          ch_we_d    = cpu_we;
          ch_addr_d  = cpu_addr;
          ch_wdata_d = cpu_wdata;
          ch_be_d    = cpu_be;
          cnt_clr    = 1'b1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        cnt_en = 1'b1;
        // ready beats the timeout when both land on the same edge
        if (ch_ready[sel_q]) begin
          rdata_d  = ch_we_q ? '0 : rd_sel;
          done_d   = 1'b1;
          ch_req_d = '0;
          state_d  = DONE;
        end else if (cnt_tc) begin
          rdata_d  = '0;
          done_d   = 1'b1;
          err_d    = 1'b1;
          ch_req_d = '0;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      ch_req_q   <= '0;
      ch_we_q    <= 1'b0;
      ch_addr_q  <= '0;
      ch_wdata_q <= '0;
      ch_be_q    <= '0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ch_req_q   <= ch_req_d;
      ch_we_q    <= ch_we_d;
      ch_addr_q  <= ch_addr_d;
      ch_wdata_q <= ch_wdata_d;
      ch_be_q    <= ch_be_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign ch_req    = ch_req_q;
  assign ch_we     = ch_we_q;
  assign ch_addr   = ch_addr_q;
  assign ch_wdata  = ch_wdata_q;
  assign ch_be     = ch_be_q;
  assign cpu_rdata = rdata_q;
  assign cpu_done  = done_q;
  assign cpu_err   = err_q;
  assign stall     = cpu_req & ~done_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Randomized self-checking bench for mio_bus_ctrl against a per-access timing model.
module tb_mio_bus_ctrl;

  localparam int DW      = 32;
  localparam int AW      = 32;
  localparam int NCH     = 4;
  localparam int TIMEOUT = 15;
  localparam int BW      = DW / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_we;
  logic [AW-1:0]     cpu_addr;
  logic [DW-1:0]     cpu_wdata;
  logic [BW-1:0]     cpu_be;
  logic [DW-1:0]     cpu_rdata;
  logic              cpu_done, cpu_err, stall;
  logic [NCH-1:0]    ch_req;
  logic              ch_we;
  logic [AW-1:0]     ch_addr;
  logic [DW-1:0]     ch_wdata;
  logic [BW-1:0]     ch_be;
  logic [NCH-1:0]    ch_ready;
  logic [NCH*DW-1:0] ch_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mio_bus_ctrl #(.DW(DW), .AW(AW), .NCH(NCH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err), .stall(stall),
    .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_be(ch_be), .ch_ready(ch_ready), .ch_rdata(ch_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n = WAIT cycle on which the addressed channel answers (0 or >TIMEOUT: never).
  // noise: 0 others quiet, 1 others always ready, 2 others random.
  task automatic access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [BW-1:0] be, input int n, input int noise, input logic hold);
    int             ch, k;
    logic           err;
    logic [DW-1:0]  exp_rd;
    logic [NCH-1:0] onehot;
    ch     = int'(addr >> (AW - $clog2(NCH)));
    onehot = NCH'(1) << ch;
    err    = !(n >= 1 && n <= TIMEOUT);
    k      = err ? TIMEOUT : n;
    exp_rd = '0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_be = be;
    ch_ready = '0;
    #1 chk("stall_accept", stall, 1);
    step();
    for (int i = 1; i <= k; i++) begin
      for (int c = 0; c < NCH; c++) ch_rdata[c*DW +: DW] = $urandom;
      case (noise)
        0:       ch_ready = '0;
        1:       ch_ready = ~onehot;
        default: ch_ready = NCH'($urandom) & ~onehot;
      endcase
      if (i == n) begin
        ch_ready[ch] = 1'b1;
        if (!we) exp_rd = ch_rdata[ch*DW +: DW];
      end
      chk("ch_req_wait", ch_req, onehot);
      chk("ch_addr", ch_addr, addr);
      chk("ch_wdata", ch_wdata, wd);
      chk("ch_we_be", {ch_we, ch_be}, {we, be});
      chk("stall_wait", {stall, cpu_done}, 2'b10);
      step();
    end
    ch_ready = '0;
    chk("done", cpu_done, 1);
    chk("err", cpu_err, err);
    chk("rdata", cpu_rdata, exp_rd);
    chk("ch_req_done", ch_req, 0);
    chk("stall_done", stall, 0);
    cpu_req = hold;
    step();
    chk("done_after", cpu_done, 0);
  endtask

  initial begin
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    ch_ready = '0; ch_rdata = '0;
    #1;
    chk("rst_ch_req", ch_req, 0);
    chk("rst_done_err", {cpu_done, cpu_err}, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_bus", {ch_we, ch_be, ch_addr, ch_wdata[15:0]}, 0);
    step(); step();
    rst = 1'b1;
    step();

    access(1'b0, 32'h8000_0010, '0, 4'hF, 1, 0, 1'b0);
    access(1'b1, 32'h0000_0040, 32'h1234_5678, 4'b0011, 5, 0, 1'b0);
    access(1'b0, 32'h4000_0000, '0, 4'hF, 0, 0, 1'b0);
    access(1'b0, 32'h4000_0100, '0, 4'hF, TIMEOUT, 1, 1'b0);
    access(1'b0, 32'hC000_0004, '0, 4'hF, 1, 0, 1'b1);
    access(1'b0, 32'h8000_0008, '0, 4'hF, 1, 0, 1'b0);

    // reset in the 3rd WAIT cycle of a write to ch2
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h8000_0020; cpu_wdata = 32'hA5A5_5A5A;
    cpu_be = 4'hF; ch_ready = '0;
    step(); step(); step();
    chk("pre_rst_req", ch_req, 4'b0100);
    rst = 1'b0;
    #1;
    chk("mid_rst_req", ch_req, 0);
    chk("mid_rst_bus", {ch_we, ch_be, ch_wdata}, 0);
    chk("mid_rst_addr", ch_addr, 0);
    chk("mid_rst_done", {cpu_done, cpu_err}, 0);
    cpu_req = 1'b0;
    step();
    chk("rst_hold_done", cpu_done, 0);
    rst = 1'b1;
    step();
    chk("post_rst_done", cpu_done, 0);

    for (int t = 0; t < 40; t++) begin
      logic [AW-1:0] a;
      a = {2'($urandom_range(0, NCH - 1)), 30'($urandom)};
      access(1'($urandom), a, DW'($urandom), BW'($urandom), $urandom_range(0, TIMEOUT + 2),
             $urandom_range(0, 2), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
